// File: rtl/code_mem_loader_pkg.sv
// rtl/code_mem_loader_pkg.sv - shared FSM encoding and frame helpers for the code memory loader
package code_mem_loader_pkg;

  // Code words are always two frame bytes wide
  localparam int DATA_WIDTH = 16;

  // Frame walk: length (lo, hi), N words (lo, hi), checksum byte
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_LO  = 3'd1,
    S_LEN_HI  = 3'd2,
    S_DATA_LO = 3'd3,
    S_DATA_HI = 3'd4,
    S_CSUM    = 3'd5
  } state_e;

  // Frame is little-endian: the low byte of every 16-bit field arrives first
  function automatic logic [DATA_WIDTH-1:0] assemble_word(input logic [7:0] first_lo,
                                                          input logic [7:0] second_hi);
    return {second_hi, first_lo};
  endfunction

  // Running checksum is a plain modulo-256 sum of every frame byte
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/code_mem_loader_if.sv
// rtl/code_mem_loader_if.sv - byte stream, code memory write port and status bundle for the loader
interface code_mem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  import code_mem_loader_pkg::*;

  logic                  start;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] mem_addr_w;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_we;
  logic                  cpu_reset;
  logic                  busy;
  logic                  done;
  logic                  error;

  // Byte source / system controller side
  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, mem_addr_w, mem_data_in, mem_we, cpu_reset, busy, done, error
  );

  // Loader side
  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, mem_addr_w, mem_data_in, mem_we, cpu_reset, busy, done, error
  );

endinterface

// File: rtl/code_mem_loader.sv
// rtl/code_mem_loader.sv - framed byte-stream loader for CPU code memory with CPU reset sequencing
module code_mem_loader
  import code_mem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  code_mem_loader_if.slave   bus
);

  // Word index is one bit wider than the address so a full 2^ADDR_WIDTH image does not wrap
  localparam int          KW        = ADDR_WIDTH + 1;
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [KW-1:0]         words_q, words_d;
  logic [KW-1:0]         k_q, k_d;
  logic [7:0]            lo_q, lo_d;
  logic [7:0]            sum_q, sum_d;

  logic                  rx_ready_q, rx_ready_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  mem_we_q, mem_we_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic [15:0]           len_full;
  logic                  len_too_big;
  logic                  len_zero;
  logic [KW-1:0]         k_inc;
  logic                  last_word;
  logic [7:0]            sum_next;
  logic                  sum_ok;

  // rx_ready is registered from the next state, so it already tracks the state we are in
  assign accept      = bus.rx_valid & rx_ready_q;
  assign len_full    = {bus.rx_data, len_lo_q};
  assign len_too_big = {1'b0, len_full} > MAX_WORDS;
  assign len_zero    = (len_full == 16'd0);
  assign k_inc       = k_q + KW'(1);
  assign last_word   = (k_inc == words_q);
  assign sum_next    = csum_add(sum_q, bus.rx_data);
  assign sum_ok      = (sum_next == 8'h00);

  // State and frame datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      len_lo_q <= '0;
      words_q  <= '0;
      k_q      <= '0;
      lo_q     <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      words_q  <= words_d;
      k_q      <= k_d;
      lo_q     <= lo_d;
      sum_q    <= sum_d;
    end
  end

  // Next-state and datapath update: one accepted byte advances the frame walk by one step
  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    words_d  = words_q;
    k_d      = k_q;
    lo_d     = lo_q;
    sum_d    = sum_q;
    if (accept) begin
      sum_d = sum_next;
    end
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LEN_LO;
          sum_d   = '0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_lo_d = bus.rx_data;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          k_d     = '0;
          words_d = len_full[KW-1:0];
          if (len_too_big) begin
            state_d = S_IDLE;
          end else if (len_zero) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA_LO;
          end
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          lo_d    = bus.rx_data;
          state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          k_d     = k_inc;
          state_d = last_word ? S_CSUM : S_DATA_LO;
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output next values: write pulse on each high byte, status flags on start / length / checksum
  always_comb begin
    rx_ready_d  = (state_d != S_IDLE);
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    cpu_reset_d = cpu_reset_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          busy_d      = 1'b1;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
        end
      end
      S_LEN_HI: begin
        if (accept && len_too_big) begin
          busy_d  = 1'b0;
          error_d = 1'b1;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          mem_we_d   = 1'b1;
          mem_addr_d = k_q[ADDR_WIDTH-1:0];
          mem_data_d = assemble_word(lo_q, bus.rx_data);
        end
      end
      S_CSUM: begin
        if (accept) begin
          busy_d = 1'b0;
          if (sum_ok) begin
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Output registers; reset releases the CPU and clears all status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ready_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_we_q    <= 1'b0;
      cpu_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      rx_ready_q  <= rx_ready_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_we_q    <= mem_we_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.rx_ready    = rx_ready_q;
  assign bus.mem_addr_w  = mem_addr_q;
  assign bus.mem_data_in = mem_data_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_code_mem_loader.sv
// tb/tb_code_mem_loader.sv - self-checking bench for code_mem_loader with a write scoreboard
module tb_code_mem_loader;
  import code_mem_loader_pkg::*;

  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  code_mem_loader_if #(.ADDR_WIDTH(AW)) bus();

  code_mem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  typedef struct {
    int n;
    bit fixed;
    bit bad;
    bit gaps;
    bit start_mid;
    bit exp_done;
    bit exp_error;
  } vec_t;

  int  n_checks    = 0;
  int  n_fail      = 0;
  int  n_writes    = 0;
  int  exp_writes  = 0;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every mem_we cycle must match the oldest expected write
  always @(negedge clk) begin
    wr_t e;
    if (!reset && bus.mem_we === 1'b1) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", bus.mem_addr_w, bus.mem_data_in);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(bus.mem_addr_w), 32'(e.addr));
        check("write_data", 32'(bus.mem_data_in), 32'(e.data));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"},  32'(bus.rx_ready),    0);
    check({tag, "_addr"},      32'(bus.mem_addr_w),  0);
    check({tag, "_data"},      32'(bus.mem_data_in), 0);
    check({tag, "_we"},        32'(bus.mem_we),      0);
    check({tag, "_cpu_reset"}, 32'(bus.cpu_reset),   0);
    check({tag, "_busy"},      32'(bus.busy),        0);
    check({tag, "_done"},      32'(bus.done),        0);
    check({tag, "_error"},     32'(bus.error),       0);
  endtask

  // Called and returns at posedge+1; holds rx_valid high until the byte is taken
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int  budget;
    int  idle;
    bit  acc;
    if (gaps) begin
      idle = $urandom_range(0, 2);
      bus.rx_valid = 1'b0;
      repeat (idle) begin
        @(posedge clk);
        #1;
      end
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    budget = 0;
    acc    = 1'b0;
    while (!acc && budget < 50) begin
      acc = bus.rx_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL byte_accept_timeout: got no accept of 0x%0h expected accept within 50 cycles", b);
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    logic [15:0] nn;
    logic [15:0] w;
    logic [7:0]  sum;
    logic [7:0]  csum;
    nn  = v.n[15:0];
    sum = 8'h00;
    pulse_start();
    check("start_busy",      32'(bus.busy),      1);
    check("start_cpu_reset", 32'(bus.cpu_reset), 1);
    check("start_rx_ready",  32'(bus.rx_ready),  1);
    check("start_done",      32'(bus.done),      0);
    check("start_error",     32'(bus.error),     0);
    send_byte(nn[7:0], v.gaps);
    sum = sum + nn[7:0];
    send_byte(nn[15:8], v.gaps);
    sum = sum + nn[15:8];
    if (v.n > (1 << AW)) begin
      bus.rx_valid = 1'b0;
      check("oversize_error",     32'(bus.error),     32'(v.exp_error));
      check("oversize_done",      32'(bus.done),      32'(v.exp_done));
      check("oversize_busy",      32'(bus.busy),      0);
      check("oversize_rx_ready",  32'(bus.rx_ready),  0);
      check("oversize_cpu_reset", 32'(bus.cpu_reset), 1);
      repeat (3) @(posedge clk);
      #1;
      check("oversize_writes", 32'(n_writes), 32'(exp_writes));
    end else begin
      for (int i = 0; i < v.n; i++) begin
        if (v.fixed) w = (i == 0) ? 16'h2011 : 16'h03b1;
        else         w = 16'($urandom);
        exp_q.push_back('{addr: AW'(i), data: w});
        exp_writes++;
        send_byte(w[7:0], v.gaps);
        send_byte(w[15:8], v.gaps);
        sum = sum + w[7:0] + w[15:8];
        if (v.start_mid && i == 0) begin
          bus.rx_valid = 1'b0;
          pulse_start();
          check("midstart_busy",     32'(bus.busy),     1);
          check("midstart_rx_ready", 32'(bus.rx_ready), 1);
          check("midstart_error",    32'(bus.error),    0);
        end
      end
      check("pre_csum_cpu_reset", 32'(bus.cpu_reset), 1);
      csum = 8'h00 - sum + (v.bad ? 8'h01 : 8'h00);
      send_byte(csum, v.gaps);
      bus.rx_valid = 1'b0;
      check("end_done",      32'(bus.done),      32'(v.exp_done));
      check("end_error",     32'(bus.error),     32'(v.exp_error));
      check("end_cpu_reset", 32'(bus.cpu_reset), 32'(!v.exp_done));
      check("end_busy",      32'(bus.busy),      0);
      check("end_rx_ready",  32'(bus.rx_ready),  0);
      repeat (2) @(posedge clk);
      #1;
      check("pending_writes", 32'(exp_q.size()), 0);
      check("write_count",    32'(n_writes),     32'(exp_writes));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    logic [15:0] w;
    vecs[0] = '{n: 2,      fixed: 1, bad: 0, gaps: 0, start_mid: 0, exp_done: 1, exp_error: 0};
    vecs[1] = '{n: 2,      fixed: 1, bad: 1, gaps: 0, start_mid: 0, exp_done: 0, exp_error: 1};
    vecs[2] = '{n: 0,      fixed: 0, bad: 0, gaps: 0, start_mid: 0, exp_done: 1, exp_error: 0};
    vecs[3] = '{n: 1,      fixed: 0, bad: 0, gaps: 1, start_mid: 1, exp_done: 1, exp_error: 0};
    vecs[4] = '{n: 'h0101, fixed: 0, bad: 0, gaps: 0, start_mid: 0, exp_done: 0, exp_error: 1};
    vecs[5] = '{n: 10,     fixed: 0, bad: 0, gaps: 0, start_mid: 0, exp_done: 1, exp_error: 0};
    vecs[6] = '{n: 256,    fixed: 0, bad: 0, gaps: 1, start_mid: 0, exp_done: 1, exp_error: 0};
    vecs[7] = '{n: 5,      fixed: 0, bad: 1, gaps: 1, start_mid: 0, exp_done: 0, exp_error: 1};
    vecs[8] = '{n: 'hffff, fixed: 0, bad: 0, gaps: 0, start_mid: 0, exp_done: 0, exp_error: 1};
    vecs[9] = '{n: 3,      fixed: 0, bad: 0, gaps: 0, start_mid: 1, exp_done: 1, exp_error: 0};

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_rx_ready", 32'(bus.rx_ready), 0);

    // Reset during word 3 of a 10-word load: words 0..2 land, then everything clears
    pulse_start();
    send_byte(8'h0a, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      w = 16'($urandom);
      exp_q.push_back('{addr: AW'(i), data: w});
      exp_writes++;
      send_byte(w[7:0], 1'b0);
      send_byte(w[15:8], 1'b0);
    end
    send_byte(8'h5a, 1'b0);
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    check_reset_vals("midload");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midload_pending", 32'(exp_q.size()), 0);
    check("midload_writes",  32'(n_writes),     32'(exp_writes));

    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
